// File: rtl/satd_pkg.sv
// Shared definitions for the SATD block controller: state encoding, counter width and
// default pipeline parameters.
package satd_pkg;

   localparam int unsigned DEF_N_SAMPLES = 16;
   localparam int unsigned DEF_PIPE_LAT  = 3;
   localparam int unsigned CNT_W         = 4;

   typedef enum logic [2:0] {
      StIdle  = 3'b000,
      StClear = 3'b001,
      StLoad  = 3'b010,
      StDrain = 3'b011,
      StDone  = 3'b100
   } satd_state_e;

endpackage

// File: rtl/satd_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins; on a tie the requester that was
// not granted last time wins.
module satd_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/satd_arb_ctrl.sv
// Arbitrates two requesters onto one SATD datapath and sequences clear, sample load,
// pipeline drain and result handshake for each 4x4 block.
module satd_arb_ctrl
   import satd_pkg::*;
#(
   parameter int unsigned PIPE_LAT  = DEF_PIPE_LAT,
   parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [1:0]       ack,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic [CNT_W-1:0] sample_idx,
   output logic             enable_counter,
   output logic             enable_diff,
   output logic             reset_diff,
   output logic             enable_sum,
   output logic             reset_sum
);

   localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CNT_W-1:0]   IDX_LAST   = CNT_W'(N_SAMPLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   satd_state_e        state_q, state_d;
   logic [1:0]         gnt_q, gnt_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [1:0]         done_q, done_d;
   logic               busy_q, busy_d;
   logic               en_cnt_q, en_cnt_d;
   logic               en_diff_q, en_diff_d;
   logic               rst_diff_q, rst_diff_d;
   logic               en_sum_q, en_sum_d;
   logic               rst_sum_q, rst_sum_d;
   logic [1:0]         arb_gnt;

   satd_rr_arb2 u_arb (
      .req  (req),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StClear;
               gnt_d   = arb_gnt;
            end
         end
         StClear: begin
            state_d = StLoad;
            idx_d   = '0;
         end
         StLoad: begin
            idx_d   = idx_q + CNT_W'(1);
            drain_d = '0;
            if (idx_q == IDX_LAST) begin
               state_d = (PIPE_LAT == 0) ? StDone : StDrain;
            end
         end
         StDrain: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = StDone;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         StDone: begin
            // Only the owner's ack releases the datapath.
            if (|(ack & gnt_q)) begin
               state_d = StIdle;
               last_d  = gnt_q[1];
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state.
      busy_d     = (state_d != StIdle);
      en_cnt_d   = (state_d == StLoad);
      en_diff_d  = (state_d == StLoad);
      en_sum_d   = (state_d == StLoad) || (state_d == StDrain);
      rst_diff_d = (state_d == StClear);
      rst_sum_d  = (state_d == StClear);
      done_d     = (state_d == StDone) ? gnt_d : 2'b00;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         last_q     <= 1'b1;
         idx_q      <= '0;
         drain_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         en_cnt_q   <= 1'b0;
         en_diff_q  <= 1'b0;
         rst_diff_q <= 1'b0;
         en_sum_q   <= 1'b0;
         rst_sum_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         drain_q    <= drain_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         en_cnt_q   <= en_cnt_d;
         en_diff_q  <= en_diff_d;
         rst_diff_q <= rst_diff_d;
         en_sum_q   <= en_sum_d;
         rst_sum_q  <= rst_sum_d;
      end
   end

   assign gnt            = gnt_q;
   assign done           = done_q;
   assign busy           = busy_q;
   assign sample_idx     = idx_q;
   assign enable_counter = en_cnt_q;
   assign enable_diff    = en_diff_q;
   assign reset_diff     = rst_diff_q;
   assign enable_sum     = en_sum_q;
   assign reset_sum      = rst_sum_q;

endmodule

// File: tb/tb_satd_arb_ctrl.sv
// Directed vector bench for satd_arb_ctrl, plus a PIPE_LAT=0 instance for the drain bypass.
module tb_satd_arb_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] req, ack, gnt, done;
   logic       busy;
   logic [3:0] sample_idx;
   logic       enable_counter, enable_diff, reset_diff, enable_sum, reset_sum;

   logic [1:0] req_p0, ack_p0, gnt_p0, done_p0;
   logic       busy_p0;
   logic [3:0] sample_idx_p0;
   logic       en_cnt_p0, en_diff_p0, rst_diff_p0, en_sum_p0, rst_sum_p0;

   satd_arb_ctrl u_dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .ack            (ack),
      .gnt            (gnt),
      .done           (done),
      .busy           (busy),
      .sample_idx     (sample_idx),
      .enable_counter (enable_counter),
      .enable_diff    (enable_diff),
      .reset_diff     (reset_diff),
      .enable_sum     (enable_sum),
      .reset_sum      (reset_sum)
   );

   satd_arb_ctrl #(.PIPE_LAT(0)) u_dut_p0 (
      .clk            (clk),
      .rst            (rst),
      .req            (req_p0),
      .ack            (ack_p0),
      .gnt            (gnt_p0),
      .done           (done_p0),
      .busy           (busy_p0),
      .sample_idx     (sample_idx_p0),
      .enable_counter (en_cnt_p0),
      .enable_diff    (en_diff_p0),
      .reset_diff     (rst_diff_p0),
      .enable_sum     (en_sum_p0),
      .reset_sum      (rst_sum_p0)
   );

   // ctl order: enable_counter, enable_diff, reset_diff, enable_sum, reset_sum
   localparam logic [4:0] CTL_OFF   = 5'b00000;
   localparam logic [4:0] CTL_CLR   = 5'b00101;
   localparam logic [4:0] CTL_LOAD  = 5'b11010;
   localparam logic [4:0] CTL_DRAIN = 5'b00010;

   typedef struct {
      logic [1:0] req;
      logic [1:0] ack;
      logic [1:0] gnt;
      logic [1:0] done;
      logic       busy;
      logic [3:0] idx;
      logic [4:0] ctl;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [13:0] obs_main();
      return {gnt, done, busy, sample_idx,
              enable_counter, enable_diff, reset_diff, enable_sum, reset_sum};
   endfunction

   function automatic logic [13:0] obs_p0();
      return {gnt_p0, done_p0, busy_p0, sample_idx_p0,
              en_cnt_p0, en_diff_p0, rst_diff_p0, en_sum_p0, rst_sum_p0};
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got gnt=%b done=%b busy=%b idx=%0d ctl=%b, want gnt=%b done=%b busy=%b idx=%0d ctl=%b",
                  name, act[13:12], act[11:10], act[9], act[8:5], act[4:0],
                  exp[13:12], exp[11:10], exp[9], exp[8:5], exp[4:0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic push_row(input logic [1:0] r, input logic [1:0] a, input logic [1:0] g,
                           input logic [1:0] d, input logic b, input logic [3:0] i,
                           input logic [4:0] c);
      vec_t v;
      v.req = r; v.ack = a; v.gnt = g; v.done = d; v.busy = b; v.idx = i; v.ctl = c;
      vecs.push_back(v);
   endtask

   task automatic push_idle(input logic [1:0] r, input logic [1:0] a);
      push_row(r, a, 2'b00, 2'b00, 1'b0, 4'd0, CTL_OFF);
   endtask

   // One full block: grant edge, 16 loads, 3 drains, then DONE awaiting ack.
   task automatic push_op(input logic [1:0] first_req, input logic [1:0] hold_req,
                          input logic [1:0] g);
      push_row(first_req, 2'b00, g, 2'b00, 1'b1, 4'd0, CTL_CLR);
      for (int i = 0; i < 16; i++) push_row(hold_req, 2'b00, g, 2'b00, 1'b1, 4'(i), CTL_LOAD);
      for (int i = 0; i < 3; i++) push_row(hold_req, 2'b00, g, 2'b00, 1'b1, 4'd0, CTL_DRAIN);
      push_row(hold_req, 2'b00, g, g, 1'b1, 4'd0, CTL_OFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bool_blk : begin end
   end

   initial begin
      int  n;
      logic seen;
      rst = 1'b1; req = 2'b00; ack = 2'b00; req_p0 = 2'b00; ack_p0 = 2'b00;

      // Single request, back-to-back on requester 0, then requester 1 wins the tie.
      push_op(2'b01, 2'b01, 2'b01);
      push_idle(2'b01, 2'b01);
      push_op(2'b01, 2'b01, 2'b01);
      push_idle(2'b11, 2'b01);
      push_op(2'b11, 2'b11, 2'b10);
      // Wrong ack is ignored, owner's ack releases.
      push_row(2'b11, 2'b01, 2'b10, 2'b10, 1'b1, 4'd0, CTL_OFF);
      push_row(2'b11, 2'b01, 2'b10, 2'b10, 1'b1, 4'd0, CTL_OFF);
      push_idle(2'b11, 2'b10);
      // Waiting requester 0 granted next; dropping req mid-block does not abort.
      push_op(2'b01, 2'b00, 2'b01);
      push_idle(2'b00, 2'b01);
      push_idle(2'b00, 2'b00);

      // Asynchronous reset, no clock edge needed.
      #2 rst = 1'b0;
      #1 check("reset_async", obs_main(), 14'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset_held", obs_main(), 14'd0);
      check("reset_held_p0", obs_p0(), 14'd0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         req = vecs[i].req;
         ack = vecs[i].ack;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), obs_main(),
               {vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].idx, vecs[i].ctl});
      end

      // Tie straight out of reset goes to requester 0.
      rst = 1'b0;
      #2 rst = 1'b1;
      req = 2'b11;
      @(posedge clk); #1;
      check("tie_after_reset", obs_main(), {2'b01, 2'b00, 1'b1, 4'd0, CTL_CLR});

      // Reset mid-LOAD at sample 7 abandons the block.
      n = 0;
      while (!(enable_counter && sample_idx == 4'd7) && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check_int("reach_idx7_cycles", n, 8);
      rst = 1'b0;
      #1 check("reset_mid_load", obs_main(), 14'd0);
      req = 2'b00;
      #1 rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (obs_main() != 14'd0) seen = 1'b1;
      end
      check_int("idle_after_reset_release", int'(seen), 0);

      // PIPE_LAT=0: done 18 cycles after the request and no drain phase.
      req_p0 = 2'b01;
      n = 0;
      seen = 1'b0;
      while (done_p0 == 2'b00 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (en_sum_p0 && !en_diff_p0) seen = 1'b1;
      end
      check_int("p0_done_latency", n, 18);
      check_int("p0_no_drain", int'(seen), 0);
      check("p0_done_state", obs_p0(), {2'b01, 2'b01, 1'b1, 4'd0, CTL_OFF});
      ack_p0 = 2'b01;
      req_p0 = 2'b00;
      @(posedge clk); #1;
      check("p0_ack_idle", obs_p0(), 14'd0);
      ack_p0 = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
